input_router_wh: RTL and testbench
==================================

Name: input_router_wh

Overview:
- Parametrised successor to the single-flit input router: a wormhole-aware, registered route-compute stage for one router input port.
- On each head flit it computes a dimension-order output port from the destination coordinates and the local router coordinates, and allocates a virtual channel.
- It locks that route and VC for the body and tail flits of the packet.
- Sits between the input buffer and the switch allocator, with valid/ready handshakes on both sides.

Parameters:
- FLIT_W, 64, flit width. Bits [FLIT_W-1:FLIT_W-2] are the flit type.
- COORD_W, 16, width of each coordinate. Head flit: dest_x = [FLIT_W-3 -: COORD_W], dest_y = the next COORD_W bits below dest_x.
- NUM_VC, 4, number of virtual channels (power of two, ≥2).
- VC_W, $clog2(NUM_VC), width of the VC index.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  input flit valid
- in_ready  output  1  stage can accept a flit
- in_flit  input  FLIT_W  incoming flit
- router_x  input  COORD_W  local router X (quasi-static)
- router_y  input  COORD_W  local router Y (quasi-static)
- out_valid  output  1  registered flit valid
- out_ready  input  1  downstream accepts
- out_flit  output  FLIT_W  registered flit, unmodified
- out_port  output  3  0=L, 1=N, 2=E, 3=S, 4=W
- out_vc  output  VC_W  allocated VC
- err  output  1  one-cycle pulse on a protocol violation

Behaviour:
- Flit types:
  - 2'b01 = head
  - 2'b00 = body
  - 2'b10 = tail
  - 2'b11 = single-flit packet (head+tail)
- Handshake:
  - A transfer occurs when valid&&ready.
  - in_ready = ~out_valid | out_ready (combinational).
  - Latency is exactly 1 cycle from input acceptance to out_valid.
  - Outputs are held stable while out_valid && !out_ready.
- Routing on head/single flits, XY order, unsigned compare:
  - dest_x > router_x → E
  - dest_x < router_x → W
  - X equal: dest_y > router_y → S (Y grows southward); dest_y < router_y → N
  - X and Y both equal → L
- VC allocation:
  - A vc_ptr register (reset 0) is assigned to out_vc on each accepted head/single flit.
  - vc_ptr then increments modulo NUM_VC.
- FSM (reset state IDLE):
  - IDLE:
    - Head accepted → latch route and VC, go to BODY.
    - Single flit accepted → emitted with computed route and VC, stay in IDLE.
    - Body or tail accepted → flit dropped (no out_valid), err=1 for one cycle, stay in IDLE.
  - BODY:
    - Body flits are emitted with the latched out_port/out_vc.
    - Tail is emitted with the latched route, then go to IDLE.
    - Head or single flit accepted → dropped, err pulse, remain in BODY. The latched route is unchanged.
- Dropped flits still consume the handshake (in_ready is not withheld).
- Back-to-back packets: a tail followed next cycle by a head is routed at full rate with no bubble.
- Reset values: out_valid=0, out_flit=0, out_port=0, out_vc=0, err=0, state=IDLE, vc_ptr=0. in_ready=1 during and after reset.
- Reset asserted mid-packet: the packet is abandoned, state returns to IDLE, and subsequent body flits raise err.
- router_x/router_y changes take effect on the next head; they never affect a locked route.

Optional Feature:
- Macro: ROUTE_YX_EN.
- When defined:
  - Adds input port route_mode (1 bit, after router_y).
  - route_mode=0 selects XY routing.
  - route_mode=1 selects YX order: Y resolved first (S/N), then X (E/W), then L.
  - route_mode is sampled only on head/single flits.
- When undefined: the port is absent and routing is XY only.

Test Plan:
- router=(1,0), single flit with dest=(1,1) → out_port=3 (S) and out_vc=0 one cycle later; err=0.
- router=(0,1), head dest=(1,1), two bodies, tail, out_ready=1 throughout → four consecutive outputs, all out_port=2 (E) with out_vc=0, then state IDLE.
- router=(0,0): single flit dest=(0,0), then single flit dest=(0,0) → both out_port=0 (L), out_vc=0 then 1. With NUM_VC=4, the 5th packet wraps to out_vc=0.
- Backpressure: head accepted, out_ready=0 for 3 cycles → in_ready=0 and out_flit/out_port held; release → next flit accepted the same cycle.
- Protocol errors: body flit in IDLE → no out_valid, err pulse. Head inside a packet → dropped, err pulse, following tail uses the original route.
- reset=1 mid-packet then released, body flit sent → err=1, out_valid stays 0. With ROUTE_YX_EN, route_mode=1, router=(0,0), dest=(2,3) → out_port=3 (S).

Source files
------------

// File: rtl/input_router_wh.sv
// Wormhole-aware registered route-compute stage for one router input port.
// Optional macro ROUTE_YX_EN adds a route_mode input selecting YX order.
module input_router_wh #(
  parameter int FLIT_W  = 64,
  parameter int COORD_W = 16,
  parameter int NUM_VC  = 4,
  parameter int VC_W    = $clog2(NUM_VC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FLIT_W-1:0]  in_flit,
  input  logic [COORD_W-1:0] router_x,
  input  logic [COORD_W-1:0] router_y,
`ifdef ROUTE_YX_EN
  input  logic               route_mode,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FLIT_W-1:0]  out_flit,
  output logic [2:0]         out_port,
  output logic [VC_W-1:0]    out_vc,
  output logic               err
);

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [2:0] {
    PORT_L = 3'd0,
    PORT_N = 3'd1,
    PORT_E = 3'd2,
    PORT_S = 3'd3,
    PORT_W = 3'd4
  } port_e;

  typedef enum logic {
    IDLE,
    BODY
  } state_e;

  state_e            state;
  port_e             lock_port;
  logic [VC_W-1:0]   lock_vc;
  logic [VC_W-1:0]   vc_ptr;

  flit_type_e        ftype;
  logic [COORD_W-1:0] dest_x;
  logic [COORD_W-1:0] dest_y;
  port_e             x_port;
  port_e             y_port;
  port_e             route_port;
  logic              accept;

  assign ftype    = flit_type_e'(in_flit[FLIT_W-1 -: 2]);
  assign dest_x   = in_flit[FLIT_W-3 -: COORD_W];
  assign dest_y   = in_flit[FLIT_W-3-COORD_W -: COORD_W];
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // Each dimension resolves independently; the order only picks which one wins.
  always_comb begin
    x_port = PORT_L;
    if (dest_x > router_x)
      x_port = PORT_E;
    else if (dest_x < router_x)
      x_port = PORT_W;

    y_port = PORT_L;
    if (dest_y > router_y)
      y_port = PORT_S;
    else if (dest_y < router_y)
      y_port = PORT_N;

`ifdef ROUTE_YX_EN
    if (route_mode)
      route_port = (y_port != PORT_L) ? y_port : x_port;
    else
      route_port = (x_port != PORT_L) ? x_port : y_port;
`else
    route_port = (x_port != PORT_L) ? x_port : y_port;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lock_port <= PORT_L;
      lock_vc   <= '0;
      vc_ptr    <= '0;
      out_valid <= 1'b0;
      out_flit  <= '0;
      out_port  <= '0;
      out_vc    <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (accept) begin
        case (state)
          IDLE: begin
            if (ftype == FT_HEAD || ftype == FT_SINGLE) begin
              out_valid <= 1'b1;
              out_flit  <= in_flit;
              out_port  <= route_port;
              out_vc    <= vc_ptr;
              vc_ptr    <= vc_ptr + VC_W'(1);
              if (ftype == FT_HEAD) begin
                lock_port <= route_port;
                lock_vc   <= vc_ptr;
                state     <= BODY;
              end
            end else begin
              err <= 1'b1;
            end
          end
          BODY: begin
            if (ftype == FT_BODY || ftype == FT_TAIL) begin
              out_valid <= 1'b1;
              out_flit  <= in_flit;
              out_port  <= lock_port;
              out_vc    <= lock_vc;
              if (ftype == FT_TAIL)
                state <= IDLE;
            end else begin
              err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_input_router_wh.sv
// Scoreboard bench for input_router_wh: driver pushes expected outputs, a
// negedge monitor pops and compares every transferred output flit.
`timescale 1ns/1ps
module tb_input_router_wh;

  localparam int FLIT_W  = 64;
  localparam int COORD_W = 16;
  localparam int NUM_VC  = 4;
  localparam int VC_W    = 2;

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [FLIT_W-1:0]  in_flit = '0;
  logic [COORD_W-1:0] router_x = '0;
  logic [COORD_W-1:0] router_y = '0;
`ifdef ROUTE_YX_EN
  logic               route_mode = 1'b0;
`endif
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [FLIT_W-1:0]  out_flit;
  logic [2:0]         out_port;
  logic [VC_W-1:0]    out_vc;
  logic               err;

  typedef struct packed {
    logic [FLIT_W-1:0] flit;
    logic [2:0]        port;
    logic [VC_W-1:0]   vc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   err_seen = 0;
  int   exp_err = 0;

  input_router_wh #(
    .FLIT_W(FLIT_W), .COORD_W(COORD_W), .NUM_VC(NUM_VC), .VC_W(VC_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_flit(in_flit),
    .router_x(router_x),
    .router_y(router_y),
`ifdef ROUTE_YX_EN
    .route_mode(route_mode),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_flit(out_flit),
    .out_port(out_port),
    .out_vc(out_vc),
    .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [15:0] dx,
                                           input logic [15:0] dy, input logic [7:0] tag);
    return {t, dx, dy, 22'd0, tag};
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pop one expectation per transferred output flit.
  always @(negedge clk) begin
    if (!reset) begin
      if (err)
        err_seen++;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_output flit=%h port=%0d vc=%0d", out_flit, out_port, out_vc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (out_flit !== e.flit || out_port !== e.port || out_vc !== e.vc) begin
            failures++;
            $display("[TB] FAIL sb_output actual flit=%h port=%0d vc=%0d expected flit=%h port=%0d vc=%0d",
                     out_flit, out_port, out_vc, e.flit, e.port, e.vc);
          end
        end
      end
    end
  end

  // Present one flit, wait (bounded) for acceptance, check the one-cycle result.
  task automatic apply_stimulus(input logic [FLIT_W-1:0] f, input logic emit,
                                input logic [2:0] port, input logic [VC_W-1:0] vc);
    int bound;
    in_valid = 1'b1;
    in_flit  = f;
    bound = 0;
    while (!in_ready && bound < 100) begin
      @(posedge clk);
      #1;
      bound++;
    end
    if (!in_ready) begin
      failures++;
      $display("[TB] FAIL accept_timeout actual=in_ready=0 expected=in_ready=1");
    end
    if (emit)
      sb.push_back('{flit: f, port: port, vc: vc});
    else
      exp_err++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_output("latency_out_valid", 64'(out_valid), 64'(emit));
    check_output("err_pulse", 64'(err), 64'(!emit));
  endtask

  task automatic end_phase(input string name);
    repeat (3) @(posedge clk);
    #1;
    check_output({name, "_drained"}, 64'(sb.size()), 64'd0);
    check_output({name, "_err_count"}, 64'(err_seen), 64'(exp_err));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_in_ready", 64'(in_ready), 64'd1);
    check_output("reset_out_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;
  endtask

  initial begin
    #1;
    check_output("rst_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_out_flit", out_flit, 64'd0);
    check_output("rst_out_port", 64'(out_port), 64'd0);
    check_output("rst_out_vc", 64'(out_vc), 64'd0);
    check_output("rst_err", 64'(err), 64'd0);
    check_output("rst_in_ready", 64'(in_ready), 64'd1);
    do_reset();

    // Single flit routes south.
    router_x = 16'd1; router_y = 16'd0;
    apply_stimulus(mk(T_SINGLE, 16'd1, 16'd1, 8'h01), 1'b1, 3'd3, 2'd0);
    end_phase("single_s");

    // Full packet east, all on VC0.
    do_reset();
    router_x = 16'd0; router_y = 16'd1;
    apply_stimulus(mk(T_HEAD, 16'd1, 16'd1, 8'h10), 1'b1, 3'd2, 2'd0);
    apply_stimulus(mk(T_BODY, 16'hAAAA, 16'h5555, 8'h11), 1'b1, 3'd2, 2'd0);
    apply_stimulus(mk(T_BODY, 16'h0000, 16'hFFFF, 8'h12), 1'b1, 3'd2, 2'd0);
    apply_stimulus(mk(T_TAIL, 16'h1234, 16'h0000, 8'h13), 1'b1, 3'd2, 2'd0);
    // Back in IDLE: a body now is a protocol error.
    apply_stimulus(mk(T_BODY, 16'd0, 16'd0, 8'h14), 1'b0, 3'd0, 2'd0);
    end_phase("packet_e");

    // Local delivery and VC wrap after NUM_VC packets.
    do_reset();
    router_x = 16'd0; router_y = 16'd0;
    for (int i = 0; i < 5; i++)
      apply_stimulus(mk(T_SINGLE, 16'd0, 16'd0, 8'(8'h20 + i)), 1'b1, 3'd0, 2'(i % NUM_VC));
    end_phase("vc_wrap");

    // Backpressure holds outputs and withholds in_ready.
    do_reset();
    router_x = 16'd0; router_y = 16'd0;
    out_ready = 1'b0;
    apply_stimulus(mk(T_HEAD, 16'd3, 16'd0, 8'h30), 1'b1, 3'd2, 2'd0);
    in_valid = 1'b1;
    in_flit  = mk(T_BODY, 16'd7, 16'd7, 8'h31);
    for (int i = 0; i < 3; i++) begin
      check_output("bp_in_ready", 64'(in_ready), 64'd0);
      check_output("bp_out_flit", out_flit, mk(T_HEAD, 16'd3, 16'd0, 8'h30));
      check_output("bp_out_port", 64'(out_port), 64'd2);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    check_output("bp_release_in_ready", 64'(in_ready), 64'd1);
    sb.push_back('{flit: mk(T_BODY, 16'd7, 16'd7, 8'h31), port: 3'd2, vc: 2'd0});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_output("bp_body_valid", 64'(out_valid), 64'd1);
    apply_stimulus(mk(T_TAIL, 16'd0, 16'd0, 8'h32), 1'b1, 3'd2, 2'd0);
    end_phase("backpressure");

    // Protocol errors and route locking.
    do_reset();
    router_x = 16'd0; router_y = 16'd0;
    apply_stimulus(mk(T_BODY, 16'd1, 16'd1, 8'h40), 1'b0, 3'd0, 2'd0);
    apply_stimulus(mk(T_TAIL, 16'd1, 16'd1, 8'h41), 1'b0, 3'd0, 2'd0);
    apply_stimulus(mk(T_HEAD, 16'd0, 16'd5, 8'h42), 1'b1, 3'd3, 2'd0);
    apply_stimulus(mk(T_HEAD, 16'd5, 16'd0, 8'h43), 1'b0, 3'd0, 2'd0);
    apply_stimulus(mk(T_SINGLE, 16'd5, 16'd0, 8'h44), 1'b0, 3'd0, 2'd0);
    router_x = 16'd9; router_y = 16'd9;
    apply_stimulus(mk(T_TAIL, 16'd0, 16'd0, 8'h45), 1'b1, 3'd3, 2'd0);
    // Tail then head next cycle: new coordinates, west then north.
    router_x = 16'd4; router_y = 16'd4;
    apply_stimulus(mk(T_HEAD, 16'd2, 16'd4, 8'h46), 1'b1, 3'd4, 2'd1);
    apply_stimulus(mk(T_TAIL, 16'd0, 16'd0, 8'h47), 1'b1, 3'd4, 2'd1);
    apply_stimulus(mk(T_SINGLE, 16'd4, 16'd1, 8'h48), 1'b1, 3'd1, 2'd2);
    apply_stimulus(mk(T_SINGLE, 16'hFFFF, 16'd0, 8'h49), 1'b1, 3'd2, 2'd3);
    end_phase("proto_err");

    // Reset mid-packet abandons it.
    do_reset();
    router_x = 16'd0; router_y = 16'd0;
    apply_stimulus(mk(T_HEAD, 16'd2, 16'd0, 8'h50), 1'b1, 3'd2, 2'd0);
    @(negedge clk);
    #1;
    do_reset();
    apply_stimulus(mk(T_BODY, 16'd0, 16'd0, 8'h51), 1'b0, 3'd0, 2'd0);
    apply_stimulus(mk(T_SINGLE, 16'd0, 16'd2, 8'h52), 1'b1, 3'd3, 2'd0);
    end_phase("reset_mid");

`ifdef ROUTE_YX_EN
    do_reset();
    router_x = 16'd0; router_y = 16'd0;
    route_mode = 1'b1;
    apply_stimulus(mk(T_SINGLE, 16'd2, 16'd3, 8'h60), 1'b1, 3'd3, 2'd0);
    apply_stimulus(mk(T_SINGLE, 16'd2, 16'd0, 8'h61), 1'b1, 3'd2, 2'd1);
    route_mode = 1'b0;
    apply_stimulus(mk(T_SINGLE, 16'd2, 16'd3, 8'h62), 1'b1, 3'd2, 2'd2);
    end_phase("yx_mode");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
